// File: rtl/muldiv_seq_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package muldiv_seq_pkg;

  // Iteration count of one operation; equals the operand width.
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_OP_MUL   = 2'd0,  // low half of product
    MD_OP_MULHU = 2'd1,  // high half of unsigned product
    MD_OP_DIVU  = 2'd2,  // unsigned quotient
    MD_OP_REMU  = 2'd3   // unsigned remainder
  } md_op_e;

  // Sequencer states kept as plain constants so older tools can consume them.
  typedef logic [1:0] md_state_e;
  localparam md_state_e MD_IDLE = 2'd0;
  localparam md_state_e MD_RUN  = 2'd1;
  localparam md_state_e MD_DONE = 2'd2;

  // Operation bundle carried by ID/EX beside the regular execute parameters.
  typedef struct packed {
    md_op_e               op;
    logic [MD_ITER-1:0]   op_a;
    logic [MD_ITER-1:0]   op_b;
  } md_params_t;

  // Multiply ops share the shift-add path; everything else is a divide.
  function automatic logic md_is_mul(input md_op_e op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULHU);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Single iteration of shift-add multiply or restoring divide.
// Latency: purely combinational, one step per call.
// Backpressure: none; the sequencer decides when to register the step.
module md_datapath
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = MD_ITER
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,     // multiplicand
  input  logic [XLEN-1:0] op_b,     // divisor
  input  logic [XLEN-1:0] hi,       // product high half / partial remainder
  input  logic [XLEN-1:0] lo,       // multiplier bits / dividend-then-quotient
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  // One multiply or divide step selected by the latched operation.
  always_comb begin
    hi_next = '0;
    lo_next = '0;
    sum     = '0;
    rem_sh  = '0;
    trial   = '0;
    if (md_is_mul(md_op_e'(op))) begin
      // Add the multiplicand when the current multiplier bit is set, keeping
      // the carry so the right shift brings it into the top of hi.
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, op_a} : '0);
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end else begin
      // Shift the next dividend bit into the remainder, then try to subtract.
      // The remainder before the shift is below the divisor, so XLEN+1 bits
      // are enough for the sign of the trial to be exact.
      rem_sh = {hi, lo[XLEN-1]};
      trial  = rem_sh - {1'b0, op_b};
      if (!trial[XLEN]) begin
        hi_next = trial[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = rem_sh[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mul/div sequencer beside EX: latches operands, iterates, returns rd data.
// Latency: accept at cycle 0, done pulse at cycle XLEN+1; pipeline stalled XLEN+1 cycles.
// Backpressure: stall held while start is high in IDLE/RUN; drops on flush or in DONE.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = MD_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  md_op_e           op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  res_q;
  logic [XLEN-1:0]  hi_next;
  logic [XLEN-1:0]  lo_next;
  logic [XLEN-1:0]  res_next;
  logic             accept;
  logic             last_iter;

  // A new op may start while idle or while handing back the previous result.
  assign accept    = start && !flush && ((state == MD_IDLE) || (state == MD_DONE));
  assign last_iter = (state == MD_RUN) && (cnt == CNT_W'(1));

  // DONE never stalls so EX captures the result in the same cycle.
  assign stall  = start && !flush && ((state == MD_IDLE) || (state == MD_RUN));
  assign done   = (state == MD_DONE);
  assign result = res_q;

  md_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .op      (op_q),
    .op_a    (a_q),
    .op_b    (b_q),
    .hi      (hi),
    .lo      (lo),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Pick the half that holds the answer once the final step completes.
  always_comb begin
    res_next = hi_next;
    case (op_q)
      MD_OP_MUL, MD_OP_DIVU: res_next = lo_next;
      default:               res_next = hi_next;
    endcase
  end

  // Sequencer FSM, iteration counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_q  <= MD_OP_MUL;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      res_q <= '0;
    end else begin
      case (state)
        MD_IDLE, MD_DONE: begin
          if (accept) begin
            op_q  <= md_op_e'(op);
            a_q   <= op_a;
            b_q   <= op_b;
            hi    <= '0;
            // Multiply shifts the multiplier out of lo; divide shifts the
            // dividend out while the quotient shifts in.
            lo    <= md_is_mul(md_op_e'(op)) ? op_b : op_a;
            cnt   <= CNT_W'(XLEN);
            state <= MD_RUN;
          end else begin
            state <= MD_IDLE;
          end
        end
        MD_RUN: begin
          if (flush) begin
            cnt   <= '0;
            state <= MD_IDLE;
          end else begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt - CNT_W'(1);
            if (last_iter) begin
              res_q <= res_next;
              state <= MD_DONE;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops vs an arithmetic model.
// Latency: checks the done pulse lands XLEN+1 cycles after accept.
// Backpressure: checks stall level every cycle of an operation.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic, divide by zero gives all ones / dividend.
  function automatic logic [31:0] ref_md(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request; caller has already positioned itself at a negedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall, input string tag);
    start = 1'b1;
    flush = 1'b0;
    op    = o;
    op_a  = a;
    op_b  = b;
    #1;
    chk({tag, "_accept_stall"}, 32'(stall), 32'(exp_stall));
  endtask

  // Wait for done with a bound; operands are scrambled meanwhile since they
  // must only be sampled on accept. Leaves the bench inside the DONE cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int lat;
    bit stall_ok;
    lat      = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      op_a = $urandom;
      op_b = $urandom;
      op   = 2'($urandom_range(0, 3));
      #1;
      lat++;
      if (!done && !stall) stall_ok = 1'b0;
    end while (!done && lat < 100);
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_stall_run"}, 32'(stall_ok), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_result"}, result, exp);
  endtask

  // Idle for n cycles with start low and confirm no stray done pulse.
  task automatic quiet(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk({tag, "_no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] held;

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'd0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    // MUL 7 x 6, then done is a single-cycle pulse and result holds.
    @(negedge clk);
    issue(2'd0, 32'd7, 32'd6, 1'b1, "mul7x6");
    wait_done("mul7x6", 32'd42);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("mul7x6_pulse_end", 32'(done), 32'd0);
    chk("mul7x6_hold", result, 32'd42);

    // Full-range products.
    @(negedge clk);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mulhu_max");
    wait_done("mulhu_max", 32'hFFFF_FFFE);
    start = 1'b0;
    @(negedge clk);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mul_max");
    wait_done("mul_max", 32'h0000_0001);
    start = 1'b0;

    // Divide, remainder and divide by zero.
    @(negedge clk);
    issue(2'd3, 32'd100, 32'd7, 1'b1, "remu100_7");
    wait_done("remu100_7", 32'd2);
    start = 1'b0;
    @(negedge clk);
    issue(2'd2, 32'd5, 32'd0, 1'b1, "divu5_0");
    wait_done("divu5_0", 32'hFFFF_FFFF);
    start = 1'b0;
    @(negedge clk);
    issue(2'd3, 32'd5, 32'd0, 1'b1, "remu5_0");
    wait_done("remu5_0", 32'd5);
    start = 1'b0;

    // Back-to-back: DIVU 100/7, then MUL 3x3 accepted in the DONE cycle.
    @(negedge clk);
    issue(2'd2, 32'd100, 32'd7, 1'b1, "b2b_divu");
    wait_done("b2b_divu", 32'd14);
    issue(2'd0, 32'd3, 32'd3, 1'b0, "b2b_mul");
    wait_done("b2b_mul", 32'd9);
    start = 1'b0;

    // Flush at cycle 10 of RUN: stall drops at once, no done afterwards.
    @(negedge clk);
    issue(2'd0, 32'd123, 32'd456, 1'b1, "flush_run");
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_run_stall", 32'(stall), 32'd0);
    chk("flush_run_done", 32'(done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    quiet(40, "flush_run");
    // Flush while idle blocks the accept.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = 2'd0;
    op_a  = 32'd9;
    op_b  = 32'd9;
    #1;
    chk("flush_idle_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    quiet(40, "flush_idle");
    @(negedge clk);
    issue(2'd0, 32'd2, 32'd2, 1'b1, "after_flush");
    wait_done("after_flush", 32'd4);
    start = 1'b0;

    // Flush in DONE: done still pulses, and a same-cycle accept is blocked.
    @(negedge clk);
    issue(2'd2, 32'd50, 32'd5, 1'b1, "flush_done");
    wait_done("flush_done", 32'd10);
    op_a  = 32'd1;
    op_b  = 32'd1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    quiet(40, "flush_done");

    // Reset at cycle 5 of RUN clears everything next cycle.
    @(negedge clk);
    issue(2'd0, 32'd1000, 32'd1000, 1'b1, "rst_run");
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_run_stall", 32'(stall), 32'd0);
    chk("rst_run_done", 32'(done), 32'd0);
    chk("rst_run_result", result, 32'd0);
    rst = 1'b0;
    quiet(40, "rst_run");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if (i % 5 == 0)               rb = 32'd0;
      else if ($urandom_range(0, 1)) rb = $urandom;
      else                           rb = 32'($urandom_range(1, 1000));
      @(negedge clk);
      issue(ro, ra, rb, 1'b1, "rnd");
      wait_done($sformatf("rnd%0d_op%0d", i, ro), ref_md(ro, ra, rb));
      held  = ref_md(ro, ra, rb);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk("rnd_pulse_end", 32'(done), 32'd0);
      chk("rnd_hold", result, held);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
